// File: rtl/pc_fetch_unit.sv
// RV32I fetch front end: owns the PC, issues single-outstanding imem fetches, one-entry IF/ID register plus one skid entry.
// Latency: request in the cycle after reset/redirect/load; IF/ID loads on the edge that sees the imem response.
// Backpressure: id_ready=0 parks at most one extra fetch in the skid entry; PC_MISALIGN_CHK_EN adds a misaligned-redirect halt.
package rv32_pkg;
    typedef enum logic {
        PC_PC4 = 1'b0,
        PC_ALU = 1'b1
    } PCSel_t;
endpackage

module pc_fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  PCSel_t      PCSel,
    input  logic [31:0] alu_result,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic [31:0] if_inst,
    input  logic        id_ready,
    output logic        misalign
);

`ifdef PC_MISALIGN_CHK_EN
    typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2, S_HALT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [31:0] buf_q, buf_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pc4_q, if_pc4_d;
    logic [31:0] if_inst_q, if_inst_d;

    logic        req_accept;
    logic        redirect_hit;
    logic        slot_free;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;
    logic        unused_alu_lsb;

    assign imem_req_valid  = (state_q == S_REQ) && !rst;
    assign imem_addr       = pc_q;
    assign req_accept      = imem_req_valid && imem_req_ready;
    assign slot_free       = !if_valid_q || id_ready;
    assign pc_plus4        = pc_q + 32'd4;
    assign redirect_target = {alu_result[31:1], 1'b0};
    assign unused_alu_lsb  = alu_result[0];

`ifdef PC_MISALIGN_CHK_EN
    logic misalign_q, misalign_d;
    // A halted unit ignores further redirects so the misalign pulse cannot repeat.
    assign redirect_hit = redirect_valid && (PCSel == PC_ALU) && (state_q != S_HALT);
    assign misalign     = misalign_q;
`else
    assign redirect_hit = redirect_valid && (PCSel == PC_ALU);
    assign misalign     = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        buf_d      = buf_q;
        if_valid_d = if_valid_q && !id_ready;
        if_pc_d    = if_pc_q;
        if_pc4_d   = if_pc4_q;
        if_inst_d  = if_inst_q;
`ifdef PC_MISALIGN_CHK_EN
        misalign_d = 1'b0;
`endif
        if (redirect_hit) begin
            pc_d       = redirect_target;
            if_valid_d = 1'b0;
            if_inst_d  = NOP_INST;
            case (state_q)
                S_REQ: begin
                    if (req_accept) begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                S_HOLD:  state_d = S_REQ;
                default: state_d = state_q;
            endcase
`ifdef PC_MISALIGN_CHK_EN
            if (alu_result[1]) begin
                misalign_d = 1'b1;
                state_d    = S_HALT;
            end
`endif
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_accept) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else if (slot_free) begin
                            if_valid_d = 1'b1;
                            if_pc_d    = pc_q;
                            if_pc4_d   = pc_plus4;
                            if_inst_d  = imem_rsp_data;
                            pc_d       = pc_plus4;
                            state_d    = S_REQ;
                        end else begin
                            buf_d   = imem_rsp_data;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // The skid entry belongs to pc_q, which only advances once it reaches IF/ID.
                    if (slot_free) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        if_pc4_d   = pc_plus4;
                        if_inst_d  = buf_q;
                        pc_d       = pc_plus4;
                        state_d    = S_REQ;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            buf_q      <= NOP_INST;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'd0;
            if_pc4_q   <= 32'd0;
            if_inst_q  <= NOP_INST;
`ifdef PC_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            buf_q      <= buf_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_pc4_q   <= if_pc4_d;
            if_inst_q  <= if_inst_d;
`ifdef PC_MISALIGN_CHK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_pc4   = if_pc4_q;
    assign if_inst  = if_inst_q;

endmodule
